// File: rtl/l2_cache_pkg.sv
// Shared types and helpers for the N-way L2 cache controller.
package l2_cache_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FILL      = 2'd2,
    ST_RESP      = 2'd3
  } state_t;

  // pmem address mux encodings
  localparam logic [1:0] ADDR_REQ = 2'b00;  // address of the current request
  localparam logic [1:0] ADDR_WB  = 2'b01;  // victim tag + set_idx

  // Widest associativity the one-hot helper supports
  localparam int MAX_WAYS = 64;

  // One-hot vector of a way index; callers size-cast down to WAYS bits
  function automatic logic [MAX_WAYS-1:0] way_onehot(input int unsigned way);
    logic [MAX_WAYS-1:0] v;
    v = {MAX_WAYS{1'b0}};
    if (way < MAX_WAYS) begin
      v[way] = 1'b1;
    end else begin
      v = {MAX_WAYS{1'b0}};
    end
    return v;
  endfunction

endpackage

// File: rtl/l2_cache_nway_control_plru.sv
// Combinational tree-PLRU: next-state bits for an access and the current victim.
// Node n (1-based heap order) is stored at bit n-1. A bit value of 0 points the
// victim search to the lower-index subtree, 1 to the upper-index subtree.
module plru_tree #(
  parameter int WAYS  = 4,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  bits,
  input  logic [WAY_W-1:0] access_way,
  output logic [WAYS-2:0]  next_bits,
  output logic [WAY_W-1:0] victim
);

  // Each node on the accessed path is flipped to point away from the access
  always_comb begin
    next_bits = bits;
    for (int d = 0; d < WAY_W; d++) begin
      for (int n = (32'sd1 << d); n < (32'sd2 << d); n++) begin
        if (int'(access_way >> (WAY_W - d)) == n - (32'sd1 << d)) begin
          next_bits[n-1] = ~access_way[WAY_W-1-d];
        end else begin
          next_bits[n-1] = bits[n-1];
        end
      end
    end
  end

  // Victim: walk the pointers from the root, one way-index bit per level
  always_comb begin : victim_walk
    logic [WAY_W-1:0] vic;
    vic = {WAY_W{1'b0}};
    for (int d = 0; d < WAY_W; d++) begin
      for (int n = (32'sd1 << d); n < (32'sd2 << d); n++) begin
        vic[WAY_W-1-d] = (int'(vic >> (WAY_W - d)) == n - (32'sd1 << d)) ?
                         bits[n-1] : vic[WAY_W-1-d];
      end
    end
    victim = vic;
  end

endmodule

// File: rtl/l2_cache_nway_control.sv
// Write-back, write-allocate N-way L2 cache controller with per-set tree-PLRU
// replacement and saturating hit/miss/writeback counters.
module l2_cache_nway_control
  import l2_cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int CNT_W = 16,
  parameter int WAY_W = $clog2(WAYS),
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [WAYS-1:0]  hit_vec,
  input  logic [WAYS-1:0]  valid_vec,
  input  logic [WAYS-1:0]  dirty_vec,
  input  logic             pmem_resp,
  output logic [WAYS-1:0]  ld_data,
  output logic [WAYS-1:0]  ld_tag,
  output logic [WAYS-1:0]  ld_valid,
  output logic [WAYS-1:0]  ld_dirty,
  output logic             dirty_in,
  output logic             fill_sel,
  output logic [WAY_W-1:0] way_sel,
  output logic [1:0]       addr_sel,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             mem_resp,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  typedef logic [WAYS-1:0] oh_t;

  state_t           state_r, state_nx_s;
  logic [WAY_W-1:0] target_r, target_nx_s;       // victim on a miss, hit way on a write hit
  logic             fill_pend_r, fill_pend_nx_s; // RESP follows a read fill
  logic [WAYS-2:0]  plru_r [SETS];
  logic [CNT_W-1:0] hit_cnt_r, miss_cnt_r, wb_cnt_r;

  logic [WAY_W-1:0] hit_way_s, inv_way_s, plru_victim_s, victim_pick_s, access_s;
  logic             hit_any_s, inv_any_s;
  logic [WAYS-2:0]  plru_cur_s, plru_next_s;
  oh_t              tgt_oh_s, hit_oh_s;
  logic             plru_we_s, hit_inc_s, miss_inc_s, wb_inc_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1'b1) : v;
  endfunction

  // Lowest-index hit way and lowest-index invalid way of the addressed set
  always_comb begin
    hit_way_s = {WAY_W{1'b0}};
    inv_way_s = {WAY_W{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_way_s = hit_vec[w]   ? WAY_W'(w) : hit_way_s;
      inv_way_s = valid_vec[w] ? inv_way_s : WAY_W'(w);
    end
  end

  assign hit_any_s     = |hit_vec;
  assign inv_any_s     = ~&valid_vec;
  assign plru_cur_s    = plru_r[set_idx];
  assign access_s      = (state_r == ST_RESP) ? target_r : hit_way_s;
  assign victim_pick_s = inv_any_s ? inv_way_s : plru_victim_s;
  assign tgt_oh_s      = oh_t'(way_onehot(32'(target_r)));
  assign hit_oh_s      = oh_t'(way_onehot(32'(hit_way_s)));

  plru_tree #(.WAYS(WAYS), .WAY_W(WAY_W)) u_plru (
    .bits       (plru_cur_s),
    .access_way (access_s),
    .next_bits  (plru_next_s),
    .victim     (plru_victim_s)
  );

  // State decode: array strobes, pmem handshake, next state and update enables
  always_comb begin
    ld_data        = {WAYS{1'b0}};
    ld_tag         = {WAYS{1'b0}};
    ld_valid       = {WAYS{1'b0}};
    ld_dirty       = {WAYS{1'b0}};
    dirty_in       = 1'b0;
    fill_sel       = 1'b0;
    way_sel        = {WAY_W{1'b0}};
    addr_sel       = ADDR_REQ;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    mem_resp       = 1'b0;
    state_nx_s     = state_r;
    target_nx_s    = target_r;
    fill_pend_nx_s = fill_pend_r;
    plru_we_s      = 1'b0;
    hit_inc_s      = 1'b0;
    miss_inc_s     = 1'b0;
    wb_inc_s       = 1'b0;
    if (rst) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_write && hit_any_s) begin
            ld_data        = hit_oh_s;
            ld_dirty       = hit_oh_s;
            dirty_in       = 1'b1;
            way_sel        = hit_way_s;
            plru_we_s      = 1'b1;
            hit_inc_s      = 1'b1;
            target_nx_s    = hit_way_s;
            fill_pend_nx_s = 1'b0;
            state_nx_s     = ST_RESP;
          end else if (mem_read && hit_any_s) begin
            mem_resp  = 1'b1;
            way_sel   = hit_way_s;
            plru_we_s = 1'b1;
            hit_inc_s = 1'b1;
          end else if (mem_read || mem_write) begin
            miss_inc_s  = 1'b1;
            target_nx_s = victim_pick_s;
            state_nx_s  = (valid_vec[victim_pick_s] && dirty_vec[victim_pick_s]) ?
                          ST_WRITEBACK : ST_FILL;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_WRITEBACK: begin
          pmem_write = 1'b1;
          addr_sel   = ADDR_WB;
          way_sel    = target_r;
          if (pmem_resp) begin
            ld_dirty   = tgt_oh_s;
            wb_inc_s   = 1'b1;
            state_nx_s = ST_FILL;
          end else begin
            state_nx_s = ST_WRITEBACK;
          end
        end
        ST_FILL: begin
          pmem_read = 1'b1;
          addr_sel  = ADDR_REQ;
          fill_sel  = 1'b1;
          way_sel   = target_r;
          if (pmem_resp) begin
            ld_data  = tgt_oh_s;
            ld_tag   = tgt_oh_s;
            ld_valid = tgt_oh_s;
            ld_dirty = tgt_oh_s;
            // A write re-enters IDLE and completes there as a write hit
            fill_pend_nx_s = ~mem_write;
            state_nx_s     = mem_write ? ST_IDLE : ST_RESP;
          end else begin
            state_nx_s = ST_FILL;
          end
        end
        ST_RESP: begin
          mem_resp       = 1'b1;
          way_sel        = target_r;
          plru_we_s      = fill_pend_r;
          fill_pend_nx_s = 1'b0;
          state_nx_s     = ST_IDLE;
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, latched way, PLRU array and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      target_r    <= {WAY_W{1'b0}};
      fill_pend_r <= 1'b0;
      hit_cnt_r   <= {CNT_W{1'b0}};
      miss_cnt_r  <= {CNT_W{1'b0}};
      wb_cnt_r    <= {CNT_W{1'b0}};
      for (int s = 0; s < SETS; s++) begin
        plru_r[s] <= {(WAYS-1){1'b0}};
      end
    end else begin
      state_r     <= state_nx_s;
      target_r    <= target_nx_s;
      fill_pend_r <= fill_pend_nx_s;
      hit_cnt_r   <= sat_inc(hit_cnt_r, hit_inc_s);
      miss_cnt_r  <= sat_inc(miss_cnt_r, miss_inc_s);
      wb_cnt_r    <= sat_inc(wb_cnt_r, wb_inc_s);
      if (plru_we_s) begin
        plru_r[set_idx] <= plru_next_s;
      end
    end
  end

  assign hit_count  = hit_cnt_r;
  assign miss_count = miss_cnt_r;
  assign wb_count   = wb_cnt_r;

endmodule

// File: tb/tb_l2_cache_nway_control.sv
// Self-checking bench: models the external tag/valid/dirty arrays and a pmem
// responder; expected response ways go through a scoreboard queue.
module tb_l2_cache_nway_control;

  localparam int WAYS = 4;
  localparam int SETS = 8;

  logic clk, rst, mem_read, mem_write, pmem_resp;
  logic [2:0] set_idx;
  logic [3:0] hit_vec, valid_vec, dirty_vec;
  logic [7:0] req_tag;
  logic arr_clr;

  logic [3:0]  ld_data, ld_tag, ld_valid, ld_dirty;
  logic        dirty_in, fill_sel, pmem_read, pmem_write, mem_resp;
  logic [1:0]  way_sel, addr_sel;
  logic [15:0] hit_count, miss_count, wb_count;

  logic [3:0] s_ld_data, s_ld_tag, s_ld_valid, s_ld_dirty;
  logic       s_dirty_in, s_fill_sel, s_pmem_read, s_pmem_write, s_mem_resp;
  logic [1:0] s_way_sel, s_addr_sel;
  logic [1:0] s_hit_count, s_miss_count, s_wb_count;

  l2_cache_nway_control #(.WAYS(WAYS), .SETS(SETS), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .set_idx(set_idx), .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
    .pmem_resp(pmem_resp), .ld_data(ld_data), .ld_tag(ld_tag), .ld_valid(ld_valid),
    .ld_dirty(ld_dirty), .dirty_in(dirty_in), .fill_sel(fill_sel), .way_sel(way_sel),
    .addr_sel(addr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .mem_resp(mem_resp), .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation
  l2_cache_nway_control #(.WAYS(WAYS), .SETS(SETS), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .set_idx(set_idx), .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
    .pmem_resp(pmem_resp), .ld_data(s_ld_data), .ld_tag(s_ld_tag), .ld_valid(s_ld_valid),
    .ld_dirty(s_ld_dirty), .dirty_in(s_dirty_in), .fill_sel(s_fill_sel), .way_sel(s_way_sel),
    .addr_sel(s_addr_sel), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
    .mem_resp(s_mem_resp), .hit_count(s_hit_count), .miss_count(s_miss_count),
    .wb_count(s_wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External arrays
  logic [7:0] tag_a   [SETS][WAYS];
  logic [3:0] valid_a [SETS];
  logic [3:0] dirty_a [SETS];

  always_comb begin
    hit_vec = 4'b0000;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_a[set_idx][w] && (tag_a[set_idx][w] == req_tag);
    end
    valid_vec = valid_a[set_idx];
    dirty_vec = dirty_a[set_idx];
  end

  always @(posedge clk) begin
    if (arr_clr) begin
      for (int s = 0; s < SETS; s++) begin
        valid_a[s] <= 4'b0000;
        dirty_a[s] <= 4'b0000;
        for (int w = 0; w < WAYS; w++) tag_a[s][w] <= 8'h00;
      end
    end else begin
      for (int w = 0; w < WAYS; w++) begin
        if (ld_tag[w])   tag_a[set_idx][w]   <= req_tag;
        if (ld_valid[w]) valid_a[set_idx][w] <= 1'b1;
        if (ld_dirty[w]) dirty_a[set_idx][w] <= dirty_in;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard and observed events
  int         exp_q[$];
  int         resp_count = 0;
  logic [1:0] wb_addr_seen, wb_way_seen;
  logic [3:0] wb_clr_seen, fill_oh_seen, wh_oh_seen;
  logic       fill_sel_seen;

  always @(negedge clk) begin
    if (mem_resp) begin
      resp_count++;
      if (exp_q.size() == 0) check_eq("spurious_resp", 32'd1, 32'd0);
      else check_eq("resp_way", 32'(way_sel), 32'(exp_q.pop_front()));
    end
    if (pmem_write) begin
      wb_addr_seen = addr_sel;
      wb_way_seen  = way_sel;
      if (pmem_resp) wb_clr_seen = dirty_in ? 4'hf : ld_dirty;
    end
    if (pmem_read) begin
      fill_sel_seen = fill_sel;
      if (pmem_resp) fill_oh_seen = ld_data;
    end
    if (!pmem_read && !pmem_write && (ld_dirty != 4'b0000))
      wh_oh_seen = dirty_in ? (ld_data & ld_dirty) : 4'hf;
  end

  // One request, answering pmem after two cycles of assertion
  task automatic do_req(input logic wr, input logic [2:0] s, input logic [7:0] tag,
                        input int exp_way);
    int pend;
    bit got;
    @(posedge clk); #1;
    exp_q.push_back(exp_way);
    mem_write = wr; mem_read = ~wr; set_idx = s; req_tag = tag;
    pend = 0; got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (mem_resp) got = 1'b1;
      else begin
        if (pmem_resp) pend = 0;
        else if (pmem_read || pmem_write) pend++;
        @(posedge clk); #1;
        pmem_resp = (pend == 2);
      end
    end
    if (!got) check_eq("req_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    bit seen;
    rst = 1'b1; arr_clr = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    pmem_resp = 1'b0; set_idx = 3'd0; req_tag = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; arr_clr = 1'b0;
    @(negedge clk);
    check_eq("rst_hit", hit_count, 32'd0);
    check_eq("rst_miss", miss_count, 32'd0);
    check_eq("rst_wb", wb_count, 32'd0);
    check_eq("rst_outs", {pmem_read, pmem_write, mem_resp, ld_data}, 32'd0);

    // Cold read of set 3 fills way 0
    r0 = resp_count; fill_sel_seen = 1'b0;
    do_req(1'b0, 3'd3, 8'h10, 0);
    check_eq("cold_fill_way", fill_oh_seen, 32'h1);
    check_eq("cold_fill_sel", fill_sel_seen, 32'd1);
    check_eq("cold_miss", miss_count, 32'd1);
    check_eq("cold_wb", wb_count, 32'd0);
    check_eq("cold_resps", resp_count - r0, 32'd1);

    // Fill the rest of set 3, then touch ways 0..3
    for (int w = 1; w < 4; w++) do_req(1'b0, 3'd3, 8'(8'h10 + w), w);
    check_eq("fill3_way", fill_oh_seen, 32'h8);
    for (int w = 0; w < 4; w++) do_req(1'b0, 3'd3, 8'(8'h10 + w), w);
    check_eq("touch_hits", hit_count, 32'd4);

    // PLRU victim after full touch sweep is way 0; then way 2
    do_req(1'b0, 3'd3, 8'h14, 0);
    check_eq("plru_victim0", fill_oh_seen, 32'h1);
    do_req(1'b0, 3'd3, 8'h14, 0);
    do_req(1'b0, 3'd3, 8'h15, 2);
    check_eq("plru_victim2", fill_oh_seen, 32'h4);

    // Dirty way 1, steer PLRU to it, then miss forces a writeback
    wh_oh_seen = 4'h0;
    do_req(1'b1, 3'd3, 8'h11, 1);
    check_eq("wr_hit_dirty", wh_oh_seen, 32'h2);
    do_req(1'b0, 3'd3, 8'h14, 0);
    do_req(1'b0, 3'd3, 8'h15, 2);
    do_req(1'b0, 3'd3, 8'h16, 1);
    check_eq("wb_addr_sel", wb_addr_seen, 32'h1);
    check_eq("wb_way_sel", wb_way_seen, 32'd1);
    check_eq("wb_clear", wb_clr_seen, 32'h2);
    check_eq("wb_fill_way", fill_oh_seen, 32'h2);
    check_eq("wb_count", wb_count, 32'd1);

    // Write miss: fill, back to IDLE, write hit, single response
    r0 = resp_count; wh_oh_seen = 4'h0;
    do_req(1'b1, 3'd5, 8'h20, 0);
    check_eq("wmiss_fill", fill_oh_seen, 32'h1);
    check_eq("wmiss_hit", wh_oh_seen, 32'h1);
    check_eq("wmiss_resps", resp_count - r0, 32'd1);
    check_eq("tot_hit", hit_count, 32'd9);
    check_eq("tot_miss", miss_count, 32'd8);
    check_eq("sat_hit", s_hit_count, 32'd3);
    check_eq("sat_miss", s_miss_count, 32'd3);

    // Reset while filling abandons the miss
    @(posedge clk); #1;
    mem_read = 1'b1; set_idx = 3'd6; req_tag = 8'h30; seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = pmem_read;
    end
    check_eq("rst_fill_entered", seen, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    check_eq("midrst_pmem", {pmem_read, pmem_write, mem_resp}, 32'd0);
    check_eq("midrst_miss", miss_count, 32'd0);
    check_eq("midrst_hit", hit_count, 32'd0);
    check_eq("midrst_noload", valid_a[6], 32'h0);
    r0 = resp_count;
    do_req(1'b0, 3'd6, 8'h30, 0);
    check_eq("post_rst_fill", fill_oh_seen, 32'h1);
    check_eq("post_rst_miss", miss_count, 32'd1);
    check_eq("post_rst_resps", resp_count - r0, 32'd1);
    check_eq("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
